// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson shift counter with direction, enable, parallel load and a wrap pulse.
// Optional illegal-state recovery is compiled in with `define SELF_CORRECT_EN.
module ring_counter_param #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shift_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             illegal;

    always_comb begin
        shift_d = q_q;
        case ({mode, dir})
            2'b00:   shift_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            2'b01:   shift_d = {q_q[0], q_q[WIDTH-1:1]};
            2'b10:   shift_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            default: shift_d = {~q_q[0], q_q[WIDTH-1:1]};
        endcase
    end

`ifdef SELF_CORRECT_EN
    // A legal Johnson code is a thermometer code: at most one adjacent-bit transition.
    logic [WIDTH-2:0] edge_w;
    generate
        for (genvar gi = 0; gi < WIDTH-1; gi++) begin : g_edge
            assign edge_w[gi] = q_q[gi] ^ q_q[gi+1];
        end
    endgenerate

    always_comb begin
        illegal = 1'b0;
        if (mode)
            illegal = ($countones(edge_w) > 1);
        else
            illegal = ($countones(q_q) != 1);
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (illegal) begin
            q_d   = INIT;
            err_d = 1'b1;
        end else if (en) begin
            q_d    = shift_d;
            wrap_d = (shift_d == INIT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= INIT;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Q    = q_q;
    assign wrap = wrap_q;
`ifdef SELF_CORRECT_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench for ring_counter_param: stimulus pushes model predictions, a monitor pops and compares.
module tb_ring_counter_param;

    localparam int         W    = 4;
    localparam logic [W-1:0] INIT = 4'b0001;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, mode, dir, load;
    logic [W-1:0] load_val;
    logic [W-1:0] Q;
    logic         wrap, err;

    ring_counter_param #(.WIDTH(W), .INIT(INIT)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .Q(Q), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         w;
        logic         e;
        string        tag;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] mq;

`ifdef SELF_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    // Reference rotation done arithmetically on the integer value.
    function automatic logic [W-1:0] ref_shift(logic [W-1:0] q, logic md, logic dr);
        int v, fb;
        v = int'(q);
        if (!dr) begin
            fb = (v >> (W-1)) & 1;
            if (md) fb = 1 - fb;
            return W'(((v * 2) % (1 << W)) + fb);
        end else begin
            fb = v & 1;
            if (md) fb = 1 - fb;
            return W'((v / 2) + fb * (1 << (W-1)));
        end
    endfunction

    // Legal ring codes are powers of two; legal Johnson codes are the 2*W thermometer codes.
    function automatic bit ref_legal(logic [W-1:0] q, logic md);
        int v, t;
        v = int'(q);
        if (!md) return (v == 1 || v == 2 || v == 4 || v == 8);
        for (int k = 0; k <= W; k++) begin
            t = (1 << k) - 1;
            if (v == t || v == ((1 << W) - 1 - t)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input logic e_i, input logic m_i, input logic d_i,
                        input logic l_i, input logic [W-1:0] lv_i, input string tag);
        exp_t x;
        @(negedge clk);
        en = e_i; mode = m_i; dir = d_i; load = l_i; load_val = lv_i;
        x.w = 1'b0; x.e = 1'b0; x.tag = tag;
        if (l_i) begin
            mq = lv_i;
        end else if (CORR && !ref_legal(mq, m_i)) begin
            mq  = INIT;
            x.e = 1'b1;
        end else if (e_i) begin
            mq  = ref_shift(mq, m_i, d_i);
            x.w = (mq == INIT);
        end
        x.q = mq;
        sb_q.push_back(x);
    endtask

    task automatic check_now(input string tag, input logic [W-1:0] eq,
                             input logic ew, input logic ee);
        n_cmp++;
        if (Q !== eq || wrap !== ew || err !== ee) begin
            n_bad++;
            $display("FAIL %s: got Q=%b wrap=%b err=%b, want Q=%b wrap=%b err=%b",
                     tag, Q, wrap, err, eq, ew, ee);
        end else begin
            $display("ok   %s: Q=%b wrap=%b err=%b", tag, Q, wrap, err);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check_now(x.tag, x.q, x.w, x.e);
            end
        end
    end

    initial begin : stim
        rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        mq = INIT;
        #7;
        check_now("reset_state", INIT, 1'b0, 1'b0);
        #13 rst = 1'b1;

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, '0, "ring_left");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, '0, "ring_right");
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, '0, "johnson_left");
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, '0, "johnson_right");
        step(1, 0, 0, 1, 4'b0100, "load_over_en");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, "hold");
        step(1, 0, 0, 1, INIT, "load_init_nowrap");
        step(1, 1, 0, 0, '0, "mode_change");
        step(1, 0, 1, 0, '0, "dir_change");

        // Asynchronous reset between edges, held across one rising edge.
        @(posedge clk);
        #3 rst = 1'b0;
        en = 1'b0; load = 1'b0;
        #1 check_now("async_reset", INIT, 1'b0, 1'b0);
        mq = INIT;
        @(negedge clk);
        @(negedge clk);
        check_now("reset_held", INIT, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, "resume");

        step(0, 0, 0, 1, 4'b0110, "load_illegal");
        step(1, 0, 0, 0, '0, "illegal_next");
        step(1, 0, 0, 0, '0, "illegal_after");
        step(0, 0, 0, 1, 4'b0000, "load_zero");
        step(1, 0, 0, 0, '0, "zero_ring");
        step(0, 1, 0, 1, 4'b0101, "load_bad_john");
        step(0, 1, 0, 0, '0, "bad_john_hold");

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] lv;
            lv = W'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                @(posedge clk);
                #3 rst = 1'b0;
                en = 1'b0; load = 1'b0;
                #1 check_now("rand_reset", INIT, 1'b0, 1'b0);
                mq = INIT;
                @(negedge clk) rst = 1'b1;
            end
            step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), lv, "random");
        end

        repeat (4) @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
